// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin bus arbiter: active-low grant/request
// encodings and the upper bound on the number of masters.
package bus_arbiter_rr_pkg;

  // Request and grant lines are active-low on this bus.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Largest arbiter this bus supports.
  localparam int BUS_ARB_MAX_MASTERS = 16;

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Arbiter handshake bundle: per-master requests in, per-master grants,
// owner index and handover pulse out.
interface bus_arbiter_rr_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int OWNER_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] req_;
  logic [NUM_MASTERS-1:0] grnt_;
  logic [OWNER_W-1:0]     owner;
  logic                   handover;

  // Masters drive requests and observe the arbitration result.
  modport master (output req_, input grnt_, input owner, input handover);

  // The arbiter samples requests and drives the result.
  modport slave (input req_, output grnt_, output owner, output handover);
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-priority search: finds the first requesting master after the
// current owner (owner+1, owner+2, ... modulo NUM_MASTERS). The owner itself
// is never a candidate, so found=1 always means a different master.
module bus_arb_rr_pick #(
  parameter int NUM_MASTERS = 4,
  localparam int OWNER_W = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [OWNER_W-1:0]     owner,
  output logic                   found,
  output logic [OWNER_W-1:0]     next_idx
);

  logic [OWNER_W:0]   sum;
  logic [OWNER_W-1:0] cand;

  // Walk candidates farthest-first so the nearest requester is assigned last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    found    = 1'b0;
    next_idx = owner;
    sum      = '0;
    cand     = '0;
    for (int k = NUM_MASTERS - 1; k >= 1; k--) begin
      sum = {1'b0, owner} + (OWNER_W + 1)'(k);
      if (sum >= (OWNER_W + 1)'(NUM_MASTERS)) begin
        sum = sum - (OWNER_W + 1)'(NUM_MASTERS);
      end
      cand = sum[OWNER_W-1:0];
      if (req[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with parking and one-cycle grant latency.
// Optional tenure limit compiled in with macro BUS_ARB_TENURE_LIMIT_EN:
// a contended owner is forced off after MAX_TENURE consecutive cycles.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_TENURE  = 16
) (
  input  logic           clk,
  input  logic           reset,
  bus_arbiter_rr_if.slave bus
);

  localparam int OWNER_W = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > BUS_ARB_MAX_MASTERS) begin : g_bad_num_masters
    $fatal(1, "bus_arbiter_rr: NUM_MASTERS=%0d outside 2..%0d", NUM_MASTERS, BUS_ARB_MAX_MASTERS);
  end
  if (MAX_TENURE < 2 || MAX_TENURE > 256) begin : g_bad_max_tenure
    $fatal(1, "bus_arbiter_rr: MAX_TENURE=%0d outside 2..256", MAX_TENURE);
  end

  logic [NUM_MASTERS-1:0] req;
  logic [OWNER_W-1:0]     owner_q;
  logic                   handover_q;
  logic                   found;
  logic [OWNER_W-1:0]     next_idx;
  logic                   expired;
  logic                   keep;
  logic                   switch_owner;

  assign req = ~bus.req_;

  bus_arb_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_pick (
    .req      (req),
    .owner    (owner_q),
    .found    (found),
    .next_idx (next_idx)
  );

`ifdef BUS_ARB_TENURE_LIMIT_EN
  localparam int TEN_W = $clog2(MAX_TENURE);
  logic [TEN_W-1:0] tenure_q;

  assign expired = (tenure_q == TEN_W'(MAX_TENURE - 1));

  // Tenure counter: restarts with each new owner, saturates once expired.
  always_ff @(posedge clk) begin
    if (reset) begin
      tenure_q <= '0;
    end else if (switch_owner) begin
      tenure_q <= '0;
    end else if (!expired) begin
      tenure_q <= tenure_q + TEN_W'(1);
    end
  end
`else
  assign expired = 1'b0;
`endif

  // Owner keeps the bus while requesting within its tenure; otherwise the
  // nearest other requester takes over, and with none the owner parks.
  assign keep         = req[owner_q] && !expired;
  assign switch_owner = !keep && found;

  // Owner register and registered handover pulse.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      owner_q    <= '0;
      handover_q <= 1'b0;
    end else begin
      owner_q    <= switch_owner ? next_idx : owner_q;
      handover_q <= switch_owner;
    end
  end

  // Grant decode: exactly one line active, the owner's.
  always_comb begin
    bus.grnt_          = {NUM_MASTERS{DISABLE_}};
    bus.grnt_[owner_q] = ENABLE_;
  end

  assign bus.owner    = owner_q;
  assign bus.handover = handover_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (4 masters, MAX_TENURE=4). Expected
// values follow BUS_ARB_TENURE_LIMIT_EN when it is defined for the build.
module tb_bus_arbiter_rr;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr_if #(.NUM_MASTERS(4)) bus ();

  bus_arbiter_rr #(
    .NUM_MASTERS(4),
    .MAX_TENURE (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks owner, decoded grants and handover against the expected owner.
  task automatic check_state(input string tag, input int exp_owner, input logic exp_ho);
    logic [3:0] exp_grnt;
    exp_grnt = ~(4'b0001 << exp_owner);
    check({tag, ".owner"},    32'(bus.owner),    32'(exp_owner));
    check({tag, ".grnt_"},    32'(bus.grnt_),    32'(exp_grnt));
    check({tag, ".handover"}, 32'(bus.handover), 32'(exp_ho));
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   exp_o;
    logic exp_h;

    // Reset held two cycles with no requests.
    reset    = 1'b1;
    bus.req_ = 4'b1111;
    tick();
    check_state("rst1", 0, 1'b0);
    tick();
    check_state("rst2", 0, 1'b0);

    // Masters 1 and 3 request: master 1 is next after owner 0.
    reset    = 1'b0;
    bus.req_ = 4'b0101;
    tick();
    check_state("m13_take", 1, 1'b1);
    tick();
    check_state("m13_hold", 1, 1'b0);

    // Only master 3 requests: owner 1 idle, moves to 3.
    bus.req_ = 4'b0111;
    tick();
    check_state("to_m3", 3, 1'b1);

    // Masters 0 and 2 request from owner 3: wraps to 0.
    bus.req_ = 4'b1010;
    tick();
    check_state("wrap_m0", 0, 1'b1);

    // Nobody requests: bus parks on 0.
    bus.req_ = 4'b1111;
    tick();
    check_state("park", 0, 1'b0);

    // Masters 0 and 1 contend from reset.
    reset    = 1'b1;
    bus.req_ = 4'b1100;
    tick();
    check_state("ten_rst", 0, 1'b0);
    reset = 1'b0;
    for (int c = 1; c < 12; c++) begin
      tick();
`ifdef BUS_ARB_TENURE_LIMIT_EN
      exp_o = ((c / 4) % 2 == 1) ? 1 : 0;
      exp_h = (c % 4 == 0);
`else
      exp_o = 0;
      exp_h = 1'b0;
`endif
      check_state($sformatf("ten_c%0d", c), exp_o, exp_h);
    end

    // Only master 2 requests: it takes the bus and keeps it past any limit.
    reset    = 1'b1;
    bus.req_ = 4'b1111;
    tick();
    reset    = 1'b0;
    bus.req_ = 4'b1011;
    tick();
    check_state("solo_take", 2, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      tick();
      check_state($sformatf("solo_c%0d", c), 2, 1'b0);
    end

    // Reset while owner 2 holds a saturated tenure and everyone requests.
    bus.req_ = 4'b0000;
    reset    = 1'b1;
    tick();
    check_state("mid_rst", 0, 1'b0);
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
`ifdef BUS_ARB_TENURE_LIMIT_EN
      exp_o = (c == 4) ? 1 : 0;
      exp_h = (c == 4);
`else
      exp_o = 0;
      exp_h = 1'b0;
`endif
      check_state($sformatf("post_rst_c%0d", c), exp_o, exp_h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
